uart_rx: RTL

Asynchronous serial receiver for the UART demo: deserialises 8N1 frames from the `uart_rxd` pin, LSB first, into bytes. It is the receive-side counterpart of the existing `auto_send` transmitter, runs in the same 50 MHz PLL domain, and feeds loopback/echo logic. It applies a 2-flop input synchronizer, validates the start bit at mid-bit, samples each bit at mid-bit, and checks the stop bit.

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer.
// Each bit is sampled at mid-bit, the start bit is validated at mid-bit, and
// the stop bit is checked.
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 frames. This adds the
// PARITY state and the parity_err port.
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       rx_busy
);

   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CW      = $clog2(BIT_CNT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic       ODD      = (PARITY_ODD != 0);
`endif

   logic [1:0]    sync_q;
   logic          rxd_s, rxd_d;
   logic [1:0]    prime;
   logic          armed;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par_bad;

   assign rxd_s = sync_q[1];

   // Synchronizer, delayed copy for edge detection, and arm logic.
   // The sync flops reset high, so their outputs are not real pin samples
   // until two cycles after reset release. prime tracks this. Arming waits
   // for prime so that a line held low through reset never looks like a
   // falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         rxd_d  <= 1'b1;
         prime  <= 2'b00;
         armed  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], uart_rxd};
         rxd_d  <= rxd_s;
         prime  <= {prime[0], 1'b1};
         if (prime[1] && rxd_s)
            armed <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   // Parity mismatch: the received bit differs from the parity computed over the data.
   assign par_bad = par_bit ^ (^shreg) ^ ODD;
`else
   assign par_bad = 1'b0;
`endif

   // Frame FSM. Each frame moves through start, data, [parity] and stop, and
   // every bit is sampled at mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (armed && !rxd_s && rxd_d) begin
                  state   <= S_START;
                  cnt     <= '0;
                  rx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rxd_s) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end else begin
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
                  end
               end else
                  cnt <= cnt + 1'b1;
            end
            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rxd_s;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
               end else
                  cnt <= cnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  par_bit <= rxd_s;
                  state   <= S_STOP;
               end else
                  cnt <= cnt + 1'b1;
            end
`endif
            S_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  state   <= S_IDLE;
                  rx_busy <= 1'b0;
                  if (!rxd_s)
                     frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (par_bad)
                     parity_err <= 1'b1;
`endif
                  if (rxd_s && !par_bad) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                  end
               end else
                  cnt <= cnt + 1'b1;
            end
            default: begin
               state   <= S_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
